// File: rtl/cpu_fwd_pkg.sv
// rtl/cpu_fwd_pkg.sv - shared scoreboard types and stage/latency codes for the forwarding unit
package cpu_fwd_pkg;

    // Entry fields are sized for the widest supported configuration; narrower
    // addresses and latencies are zero-extended on entry.
    localparam int SB_ADDR_W = 8;
    localparam int SB_LAT_W  = 4;

    typedef struct packed {
        logic                 valid;
        logic                 wen;
        logic [SB_ADDR_W-1:0] dst;
        logic [SB_LAT_W-1:0]  lat;
    } sb_entry_t;

    localparam int FWD_RF     = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - issue/operand/bypass bundle between ID stage and forwarding unit
interface fwd_scoreboard_if #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 2,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
);
    logic                      issue_valid;
    logic                      issue_wen;
    logic [ADDR_W-1:0]         issue_dst;
    logic [LAT_W-1:0]          issue_lat;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_used;
    logic                      hold;
    logic                      flush;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall;
    logic                      issue_fire;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output issue_valid, issue_wen, issue_dst, issue_lat,
        output src_addr, src_used, hold, flush,
        input  fwd_sel, stall, issue_fire, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_wen, issue_dst, issue_lat,
        input  src_addr, src_used, hold, flush,
        output fwd_sel, stall, issue_fire, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard_match.sv
// rtl/fwd_scoreboard_match.sv - youngest-writer priority search for one source operand
module fwd_match
    import cpu_fwd_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 2
) (
    input  sb_entry_t [DEPTH:1] ent,
    input  logic                used,
    input  logic [ADDR_W-1:0]   addr,
    output logic [SEL_W-1:0]    sel,
    output logic                stall_i
);
    logic found;

    always_comb begin
        sel     = SEL_W'(FWD_RF);
        stall_i = 1'b0;
        found   = 1'b0;
        // r0 is hard-wired zero, so a write to it never needs forwarding.
        if (used && (addr != '0)) begin
            for (int s = 1; s <= DEPTH; s++) begin
                if (!found && ent[s].valid && ent[s].wen &&
                    (ent[s].dst == SB_ADDR_W'(addr))) begin
                    found = 1'b1;
                    if (s > int'(ent[s].lat)) begin
                        sel = SEL_W'(s);
                    end else begin
                        stall_i = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight write scoreboard producing bypass selects and issue stall
module fwd_scoreboard
    import cpu_fwd_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int LAT_W   = 2,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          reset,
    fwd_scoreboard_if.slave sb
);
    sb_entry_t [DEPTH:1]      ent_q, ent_d;
    logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC*SEL_W-1:0] sel_w;
    logic [NUM_SRC-1:0]       stall_vec;
    logic                     stall;
    logic                     fire;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_match (
            .ent     (ent_q),
            .used    (sb.src_used[i]),
            .addr    (sb.src_addr[i*ADDR_W +: ADDR_W]),
            .sel     (sel_w[i*SEL_W +: SEL_W]),
            .stall_i (stall_vec[i])
        );
    end

    assign stall = sb.issue_valid & (|stall_vec);
    assign fire  = reset & sb.issue_valid & ~stall & ~sb.hold & ~sb.flush;

    always_comb begin
        ent_d = ent_q;
        if (!sb.hold) begin
            for (int s = DEPTH; s >= 2; s--) begin
                ent_d[s] = ent_q[s-1];
            end
            if (fire) begin
                ent_d[1] = '{valid: 1'b1,
                             wen:   sb.issue_wen,
                             dst:   SB_ADDR_W'(sb.issue_dst),
                             lat:   SB_LAT_W'(sb.issue_lat)};
            end else begin
                ent_d[1] = '0;
            end
        end
        // A redirect kills stage 1 even while the rest of the pipe is frozen.
        if (sb.flush) begin
            ent_d[1] = '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !sb.hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb.fwd_sel    = sel_w;
    assign sb.stall      = stall;
    assign sb.issue_fire = fire;
    assign sb.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed table and randomized model check of fwd_scoreboard
module tb_fwd_scoreboard;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int DEPTH   = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.CNT_W(CNT_W)) bus ();

    fwd_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
    );

    typedef struct {
        bit v;
        bit wen;
        int dst;
        int lat;
    } rec_t;

    typedef struct {
        bit v; bit w; int d; int l; int s0; int s1; int u; bit h; bit f;
        int e0; int e1; int est; int efire; int ecnt;
    } vec_t;

    rec_t hist [0:8191];
    int   adv  = 0;
    int   base = 0;
    int   mcnt = 0;
    int   m_sel0, m_sel1, m_stall, m_fire;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl [24];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stage s holds whatever was pushed s pipe advances ago.
    function automatic int model_src(input int a, input bit used, output int st);
        st = 0;
        if (!used || a == 0) return 0;
        for (int s = 1; s <= DEPTH; s++) begin
            int idx = adv - s;
            if (idx < base) return 0;
            if (hist[idx].v && hist[idx].wen && hist[idx].dst == a) begin
                if (s > hist[idx].lat) return s;
                st = 1;
                return 0;
            end
        end
        return 0;
    endfunction

    task automatic model_eval();
        int st0, st1;
        m_sel0  = model_src(int'(bus.src_addr[4:0]), bus.src_used[0], st0);
        m_sel1  = model_src(int'(bus.src_addr[9:5]), bus.src_used[1], st1);
        m_stall = (bus.issue_valid && (st0 != 0 || st1 != 0)) ? 1 : 0;
        m_fire  = (reset && bus.issue_valid && m_stall == 0 && !bus.hold && !bus.flush) ? 1 : 0;
    endtask

    task automatic model_update();
        if (!reset) return;
        if (m_stall != 0 && !bus.hold && mcnt < CNT_MAX) mcnt++;
        if (!bus.hold) begin
            hist[adv].v   = (m_fire != 0);
            hist[adv].wen = bus.issue_wen;
            hist[adv].dst = int'(bus.issue_dst);
            hist[adv].lat = int'(bus.issue_lat);
            adv++;
        end
        if (bus.flush && adv - 1 >= base) hist[adv-1].v = 1'b0;
    endtask

    task automatic drive(input bit v, input bit w, input int d, input int l,
                         input int s0, input int s1, input int u, input bit h, input bit f);
        bus.issue_valid = v;
        bus.issue_wen   = w;
        bus.issue_dst   = 5'(d);
        bus.issue_lat   = 2'(l);
        bus.src_addr    = {5'(s1), 5'(s0)};
        bus.src_used    = 2'(u);
        bus.hold        = h;
        bus.flush       = f;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " fwd_sel"},    int'(bus.fwd_sel),    0);
        chk({tag, " stall"},      int'(bus.stall),      0);
        chk({tag, " issue_fire"}, int'(bus.issue_fire), 0);
        chk({tag, " stall_cnt"},  int'(bus.stall_cnt),  0);
    endtask

    task automatic drive_random();
        drive(($urandom % 4) != 0, 1'($urandom), $urandom % 4, $urandom % 4,
              $urandom % 4, $urandom % 4, $urandom % 4,
              ($urandom % 8) == 0, ($urandom % 8) == 0);
    endtask

    initial begin
        tbl[0]  = '{1,1,5,0, 0,0,3,0,0, 0,0,0,1,0};
        tbl[1]  = '{1,0,0,0, 5,0,1,0,0, 1,0,0,1,0};
        tbl[2]  = '{1,0,0,0, 5,0,1,0,0, 2,0,0,1,0};
        tbl[3]  = '{1,0,0,0, 5,0,1,0,0, 3,0,0,1,0};
        tbl[4]  = '{1,0,0,0, 5,0,1,0,0, 0,0,0,1,0};
        tbl[5]  = '{1,1,7,1, 0,0,0,0,0, 0,0,0,1,0};
        tbl[6]  = '{1,0,0,0, 0,7,2,0,0, 0,0,1,0,0};
        tbl[7]  = '{1,0,0,0, 0,7,2,0,0, 0,2,0,1,1};
        tbl[8]  = '{1,1,3,0, 0,0,0,0,0, 0,0,0,1,1};
        tbl[9]  = '{1,1,3,0, 0,0,0,0,0, 0,0,0,1,1};
        tbl[10] = '{1,1,0,0, 3,0,1,0,0, 1,0,0,1,1};
        tbl[11] = '{1,0,0,0, 0,0,3,0,0, 0,0,0,1,1};
        tbl[12] = '{1,1,9,1, 0,0,0,0,0, 0,0,0,1,1};
        tbl[13] = '{1,0,0,0, 9,0,1,1,0, 0,0,1,0,1};
        tbl[14] = '{1,0,0,0, 9,0,1,1,0, 0,0,1,0,1};
        tbl[15] = '{1,0,0,0, 9,0,1,1,0, 0,0,1,0,1};
        tbl[16] = '{1,0,0,0, 9,0,1,1,0, 0,0,1,0,1};
        tbl[17] = '{1,0,0,0, 9,0,1,0,0, 0,0,1,0,1};
        tbl[18] = '{1,0,0,0, 9,0,1,0,0, 2,0,0,1,2};
        tbl[19] = '{1,1,4,0, 0,0,0,0,1, 0,0,0,0,2};
        tbl[20] = '{1,0,0,0, 4,0,1,0,0, 0,0,0,1,2};
        tbl[21] = '{1,1,6,1, 0,0,0,0,0, 0,0,0,1,2};
        tbl[22] = '{1,0,0,0, 6,0,1,0,1, 0,0,1,0,2};
        tbl[23] = '{1,0,0,0, 6,0,1,0,0, 2,0,0,1,3};

        // Reset held low with random inputs.
        reset = 1'b0;
        drive_random();
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            drive_random();
            #1;
            check_reset_outputs("rst_low");
            tick();
        end
        reset = 1'b1;

        // Directed sequence.
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].d, tbl[i].l, tbl[i].s0, tbl[i].s1,
                  tbl[i].u, tbl[i].h, tbl[i].f);
            #1;
            model_eval();
            chk($sformatf("vec%0d sel0", i),  int'(bus.fwd_sel[1:0]), tbl[i].e0);
            chk($sformatf("vec%0d sel1", i),  int'(bus.fwd_sel[3:2]), tbl[i].e1);
            chk($sformatf("vec%0d stall", i), int'(bus.stall),        tbl[i].est);
            chk($sformatf("vec%0d fire", i),  int'(bus.issue_fire),   tbl[i].efire);
            chk($sformatf("vec%0d cnt", i),   int'(bus.stall_cnt),    tbl[i].ecnt);
            tick();
        end

        // Randomized run against the reference model, with a mid-stream reset.
        for (int c = 0; c < 600; c++) begin
            drive_random();
            if (c == 300) begin
                reset = 1'b0;
                #1;
                check_reset_outputs("mid_rst");
                base = adv;
                mcnt = 0;
                tick();
                reset = 1'b1;
                continue;
            end
            #1;
            model_eval();
            chk("rnd sel0",  int'(bus.fwd_sel[1:0]), m_sel0);
            chk("rnd sel1",  int'(bus.fwd_sel[3:2]), m_sel1);
            chk("rnd stall", int'(bus.stall),        m_stall);
            chk("rnd fire",  int'(bus.issue_fire),   m_fire);
            chk("rnd cnt",   int'(bus.stall_cnt),    mcnt);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
